// File: rtl/dmem_pkg.sv
// Shared types and helpers for the data-memory responder slice.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam int WORD_BYTES = 4;

  function automatic logic [31:0] be_merge(input logic [31:0] old_word,
                                           input logic [31:0] wdata,
                                           input logic [3:0]  be);
    logic [31:0] merged;
    merged = old_word;
    for (int i = 0; i < WORD_BYTES; i++) begin
      if (be[i]) merged[8*i +: 8] = wdata[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/dmem_responder_if.sv
// Load/store request and response bundle between the pipeline and the data memory.
interface dmem_responder_if;
  logic        req_valid;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic [3:0]  req_be;
  logic        req_ready;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_be,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_be,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_array.sv
// Word-wide synchronous RAM with per-byte write enables and a registered read port.
module dmem_array
  import dmem_pkg::*;
#(
  parameter  int DEPTH_WORDS = 256,
  localparam int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          en,
  input  logic          we,
  input  logic [AW-1:0] idx,
  input  logic [31:0]   wdata,
  input  logic [3:0]    be,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Read returns the word as it was before this edge's write.
  always_ff @(posedge clk) begin
    if (en) begin
      if (we) mem[idx] <= be_merge(mem[idx], wdata, be);
      rdata <= mem[idx];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Multi-cycle data-memory responder: accepts one request, waits LATENCY cycles, responds once.
module dmem_responder
  import dmem_pkg::*;
#(
  parameter int          DEPTH_WORDS = 256,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          LATENCY     = 2
) (
  input  logic             clk,
  input  logic             reset,
  dmem_responder_if.slave  bus
);

  localparam int         AW   = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN = 33'(DEPTH_WORDS) * 33'(WORD_BYTES);
  localparam logic [3:0] LAT  = 4'(LATENCY);

  state_t      state;
  logic [3:0]  cnt;

  logic        we_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  be_q;

  logic          accept;
  logic          to_resp;
  logic          cur_we;
  logic [31:0]   cur_addr;
  logic [31:0]   cur_wdata;
  logic [3:0]    cur_be;
  logic [31:0]   off;
  logic          cur_err;
  logic [AW-1:0] cur_idx;
  logic [31:0]   rdata;
  logic          in_resp;

  assign bus.req_ready = (state == IDLE) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;

  // In IDLE the live bus is the request (needed when LATENCY=0); afterwards the captured copy.
  always_comb begin
    cur_we    = we_q;
    cur_addr  = addr_q;
    cur_wdata = wdata_q;
    cur_be    = be_q;
    if (state == IDLE) begin
      cur_we    = bus.req_we;
      cur_addr  = bus.req_addr;
      cur_wdata = bus.req_wdata;
      cur_be    = bus.req_be;
    end
  end

  assign off     = cur_addr - BASE_ADDR;
  assign cur_err = (cur_addr[1:0] != 2'b00) || ({1'b0, off} >= SPAN);
  assign cur_idx = off[AW+1:2];

  assign to_resp = !reset &&
                   ((accept && (LAT == 4'd0)) ||
                    ((state == WAIT) && ((cnt + 4'd1) == LAT)));

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= 4'd0;
    end else begin
      case (state)
        IDLE: begin
          cnt <= 4'd0;
          if (accept) state <= (LAT == 4'd0) ? RESP : WAIT;
        end
        WAIT: begin
          cnt <= cnt + 4'd1;
          if ((cnt + 4'd1) == LAT) state <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // Request capture: data path, deliberately not reset.
  always_ff @(posedge clk) begin
    if (accept) begin
      we_q    <= bus.req_we;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
      be_q    <= bus.req_be;
    end
  end

  dmem_array #(
    .DEPTH_WORDS (DEPTH_WORDS)
  ) u_array (
    .clk   (clk),
    .en    (to_resp),
    .we    (cur_we && !cur_err),
    .idx   (cur_idx),
    .wdata (cur_wdata),
    .be    (cur_be),
    .rdata (rdata)
  );

  // Response fields are forced to zero outside the single response cycle.
  assign in_resp       = (state == RESP) && !reset;
  assign bus.rsp_valid = in_resp;
  assign bus.rsp_err   = in_resp && cur_err;
  assign bus.rsp_rdata = (in_resp && !cur_we && !cur_err) ? rdata : 32'h0;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: LATENCY=2 and LATENCY=0 instances.
module tb_dmem_responder;

  logic clk = 1'b0;
  logic reset2, reset0;
  always #5 clk = ~clk;

  dmem_responder_if if2 ();
  dmem_responder_if if0 ();

  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(2)) u2 (
    .clk(clk), .reset(reset2), .bus(if2));
  dmem_responder #(.DEPTH_WORDS(256), .BASE_ADDR(32'h0), .LATENCY(0)) u0 (
    .clk(clk), .reset(reset0), .bus(if0));

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    logic        exp_err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[15];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", nm, act, exp);
    end
  endtask

  // One full transaction on the LATENCY=2 instance, checking timing and response.
  task automatic xact2(input logic we, input logic [31:0] a, input logic [31:0] wd,
                       input logic [3:0] be, input logic exp_err, input logic [31:0] exp_rd,
                       input string nm);
    int lat;
    bit quiet;
    @(negedge clk);
    chk({nm, "_ready"}, 32'(if2.req_ready), 32'd1);
    if2.req_valid = 1'b1;
    if2.req_we    = we;
    if2.req_addr  = a;
    if2.req_wdata = wd;
    if2.req_be    = be;
    @(negedge clk);
    if2.req_valid = 1'b0;
    if2.req_addr  = 32'h0000_0044;
    if2.req_wdata = 32'hFFFF_FFFF;
    lat   = 0;
    quiet = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      if (if2.rsp_valid) begin
        lat = c;
        break;
      end
      if (if2.req_ready || if2.rsp_err || (if2.rsp_rdata != 32'h0)) quiet = 1'b0;
      @(negedge clk);
    end
    chk({nm, "_latency"}, 32'(lat), 32'd3);
    chk({nm, "_wait_quiet"}, 32'(quiet), 32'd1);
    chk({nm, "_err"}, 32'(if2.rsp_err), 32'(exp_err));
    chk({nm, "_rdata"}, if2.rsp_rdata, exp_rd);
    chk({nm, "_ready_in_resp"}, 32'(if2.req_ready), 32'd0);
    @(negedge clk);
    chk({nm, "_single_rsp"}, 32'(if2.rsp_valid), 32'd0);
    chk({nm, "_ready_again"}, 32'(if2.req_ready), 32'd1);
  endtask

  initial begin
    logic [31:0] d;
    vecs[0]  = '{1'b1, 32'h10,  32'hDEADBEEF, 4'hF,    1'b0, 32'h0};
    vecs[1]  = '{1'b0, 32'h10,  32'h0,        4'h0,    1'b0, 32'hDEADBEEF};
    vecs[2]  = '{1'b1, 32'h20,  32'h11223344, 4'hF,    1'b0, 32'h0};
    vecs[3]  = '{1'b1, 32'h20,  32'hAABBCCDD, 4'b0101, 1'b0, 32'h0};
    vecs[4]  = '{1'b0, 32'h20,  32'h0,        4'h0,    1'b0, 32'h11BB33DD};
    vecs[5]  = '{1'b1, 32'h22,  32'h55555555, 4'hF,    1'b1, 32'h0};
    vecs[6]  = '{1'b0, 32'h400, 32'h0,        4'h0,    1'b1, 32'h0};
    vecs[7]  = '{1'b0, 32'h20,  32'h0,        4'h0,    1'b0, 32'h11BB33DD};
    vecs[8]  = '{1'b1, 32'h24,  32'h12345678, 4'h0,    1'b0, 32'h0};
    vecs[9]  = '{1'b0, 32'h24,  32'h0,        4'h0,    1'b0, 32'h0};
    vecs[10] = '{1'b1, 32'h3FC, 32'h0BADCAFE, 4'hF,    1'b0, 32'h0};
    vecs[11] = '{1'b0, 32'h3FC, 32'h0,        4'h0,    1'b0, 32'h0BADCAFE};
    vecs[12] = '{1'b0, 32'h3FD, 32'h0,        4'h0,    1'b1, 32'h0};
    vecs[13] = '{1'b1, 32'hFFFFFFFC, 32'h77777777, 4'hF, 1'b1, 32'h0};
    vecs[14] = '{1'b0, 32'h0,   32'h0,        4'h0,    1'b0, 32'h0};

    reset2 = 1'b1;
    reset0 = 1'b1;
    if2.req_valid = 1'b0; if2.req_we = 1'b0; if2.req_addr = 32'h0;
    if2.req_wdata = 32'h0; if2.req_be = 4'h0;
    if0.req_valid = 1'b0; if0.req_we = 1'b0; if0.req_addr = 32'h0;
    if0.req_wdata = 32'h0; if0.req_be = 4'h0;

    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk("reset_ready", 32'(if2.req_ready), 32'd0);
      chk("reset_rsp_valid", 32'(if2.rsp_valid), 32'd0);
      chk("reset_rdata", if2.rsp_rdata, 32'h0);
    end
    reset2 = 1'b0;
    reset0 = 1'b0;
    @(negedge clk);
    chk("post_reset_ready2", 32'(if2.req_ready), 32'd1);
    chk("post_reset_ready0", 32'(if0.req_ready), 32'd1);
    chk("post_reset_rsp_valid", 32'(if2.rsp_valid), 32'd0);

    for (int i = 0; i < 15; i++)
      xact2(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].be,
            vecs[i].exp_err, vecs[i].exp_rd, $sformatf("vec%0d", i));

    // Reset one cycle after accepting a store: nothing must be written or answered.
    @(negedge clk);
    if2.req_valid = 1'b1; if2.req_we = 1'b1; if2.req_addr = 32'h30;
    if2.req_wdata = 32'hCAFEF00D; if2.req_be = 4'hF;
    @(negedge clk);
    if2.req_valid = 1'b0;
    reset2 = 1'b1;
    chk("rst_wait_rsp", 32'(if2.rsp_valid), 32'd0);
    @(negedge clk);
    reset2 = 1'b0;
    chk("rst_wait_rsp_hold", 32'(if2.rsp_valid), 32'd0);
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      chk("rst_no_late_rsp", 32'(if2.rsp_valid), 32'd0);
    end
    chk("rst_ready_back", 32'(if2.req_ready), 32'd1);
    xact2(1'b0, 32'h30, 32'h0, 4'h0, 1'b0, 32'h0, "rst_load30");

    // LATENCY=0 stream with req_valid held high; bus changes during RESP must be ignored.
    @(negedge clk);
    if0.req_valid = 1'b1;
    for (int k = 0; k < 8; k++) begin
      d = 32'h1000_0001 + 32'(k % 4) * 32'h0101_0101;
      chk($sformatf("l0_ready%0d", k), 32'(if0.req_ready), 32'd1);
      if0.req_we    = (k < 4);
      if0.req_addr  = 32'(k % 4) * 32'd4;
      if0.req_wdata = d;
      if0.req_be    = 4'hF;
      @(negedge clk);
      chk($sformatf("l0_rsp_valid%0d", k), 32'(if0.rsp_valid), 32'd1);
      chk($sformatf("l0_err%0d", k), 32'(if0.rsp_err), 32'd0);
      chk($sformatf("l0_rdata%0d", k), if0.rsp_rdata, (k < 4) ? 32'h0 : d);
      chk($sformatf("l0_busy%0d", k), 32'(if0.req_ready), 32'd0);
      if0.req_we    = 1'b1;
      if0.req_addr  = 32'h40;
      if0.req_wdata = 32'hFFFF_FFFF;
      @(negedge clk);
    end
    if0.req_valid = 1'b0;
    chk("l0_idle_rsp", 32'(if0.rsp_valid), 32'd0);
    @(negedge clk);
    if0.req_valid = 1'b1; if0.req_we = 1'b0; if0.req_addr = 32'h40;
    @(negedge clk);
    if0.req_valid = 1'b0;
    chk("l0_ignored_rsp", 32'(if0.rsp_valid), 32'd1);
    chk("l0_ignored_data", if0.rsp_rdata, 32'h0);
    @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
